// File: rtl/mini_core_pkg.sv
// mini_core_pkg: shared fetch-stage defaults and the request-gating helper
package mini_core_pkg;
   localparam int ADDR_W = 8;
   localparam int INSTR_W = 16;
   localparam logic [7:0] RESET_PC = 8'h00;
   localparam logic [15:0] NOP_INSTR = 16'h0000;
   localparam int FIFO_DEPTH = 2;
   function automatic logic can_fetch(input logic [1:0] count, input logic inflight, input logic pop);
      return ({1'b0, count} + {2'b0, inflight} - {2'b0, pop}) < 3'(FIFO_DEPTH);
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {pc, instr} buffer; flush beats push
module fetch_fifo #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);
   logic [W-1:0] mem_q [2];
   logic         rd_q, wr_q;
   logic [1:0]   count_q;
   assign dout  = mem_q[rd_q];
   assign count = count_q;
   // storage, pointers and occupancy; a flush empties the buffer regardless of push/pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush) begin
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         count_q <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= din;
            wr_q        <= !wr_q;
         end
         if (pop) rd_q <= !rd_q;
         count_q <= count_q + 2'(push) - 2'(pop);
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing 1-cycle imem reads into a 2-entry buffer for the core
module fetch_stage #(
   parameter int                ADDR_W   = mini_core_pkg::ADDR_W,
   parameter int                INSTR_W  = mini_core_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = mini_core_pkg::RESET_PC
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc
);
   import mini_core_pkg::can_fetch;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, req_pc_q;
   logic              inflight_q, squash_q;
   logic [1:0]        count;
   logic              pop, push;
   assign out_valid = count != 2'd0;
   assign pop       = out_valid & out_ready;
   assign imem_req  = !rst & !redirect_valid & can_fetch(count, inflight_q, pop);
   assign imem_addr = fetch_pc_q;
   assign push      = inflight_q & !squash_q;
   // redirect retargets the PC; otherwise it advances on every issued request
   always_comb fetch_pc_d = redirect_valid ? redirect_pc : imem_req ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
   // request bookkeeping: every request returns next cycle, so inflight simply tracks the last req
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
         squash_q   <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= imem_req;
         squash_q   <= redirect_valid & inflight_q;
         if (imem_req) req_pc_q <= fetch_pc_q;
      end
   end
   fetch_fifo #(.W(ADDR_W + INSTR_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   ({req_pc_q, imem_rdata}),
      .dout  ({out_pc, out_instr}),
      .count (count)
   );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: cycle table plus scoreboard of delivered {pc, instr} for fetch_stage
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata = 16'h0;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instr;
   logic [7:0]  out_pc;
   int          errors = 0;
   int          checks = 0;
   int          pops = 0;
   logic [7:0]  exp_q [$];

   typedef struct {
      bit         rf;
      bit         rdy;
      bit         req;
      logic [7:0] addr;
      bit         vld;
      logic [7:0] pc;
   } vec_t;
   vec_t tbl [17];

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (imem_req) imem_rdata <= 16'hA000 | {8'h00, imem_addr};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic restart(input logic [7:0] start);
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(start + 8'(i));
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         pops++;
         if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("sb_pc", int'(out_pc), int'(e));
            chk("sb_instr", int'(out_instr), int'(16'hA000 | {8'h00, e}));
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      restart(8'h00);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_pops(input int n, input string name);
      int start;
      start = pops;
      for (int i = 0; i < 30 && pops - start < n; i++) @(posedge clk);
      chk(name, int'(pops - start >= n), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 8'h00;
      out_ready = 1'b1;
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 8'h00};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 8'h01};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 8'h02};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 8'h03};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
      tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 8'h00};
      tbl[14] = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 8'h01};
      tbl[15] = '{1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 8'h02};
      tbl[16] = '{1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 8'h03};
      for (int i = 0; i < 17; i++) begin
         if (tbl[i].rf) do_reset();
         out_ready = tbl[i].rdy;
         @(negedge clk);
         chk($sformatf("tbl%0d_req", i), int'(imem_req), int'(tbl[i].req));
         if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), int'(imem_addr), int'(tbl[i].addr));
         chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].vld));
         if (tbl[i].vld) begin
            chk($sformatf("tbl%0d_pc", i), int'(out_pc), int'(tbl[i].pc));
            chk($sformatf("tbl%0d_instr", i), int'(out_instr), int'(16'hA000 | {8'h00, tbl[i].pc}));
         end
         @(posedge clk);
         #1;
      end
      redirect_valid = 1'b1;
      redirect_pc = 8'h40;
      @(negedge clk);
      chk("t3_no_req", int'(imem_req), 0);
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      restart(8'h40);
      @(negedge clk);
      chk("t3_valid_drop", int'(out_valid), 0);
      chk("t3_req", int'(imem_req), 1);
      chk("t3_addr", int'(imem_addr), 'h40);
      wait_pops(3, "t3_delivery");
      redirect_valid = 1'b1;
      redirect_pc = 8'hFE;
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      restart(8'hFE);
      wait_pops(4, "t4_wrap_delivery");
      redirect_valid = 1'b1;
      redirect_pc = 8'h10;
      @(posedge clk);
      #1 redirect_pc = 8'h20;
      @(negedge clk);
      chk("t5_no_valid", int'(out_valid), 0);
      chk("t5_no_req", int'(imem_req), 0);
      @(posedge clk);
      #1 redirect_valid = 1'b0;
      restart(8'h20);
      @(negedge clk);
      chk("t5_addr", int'(imem_addr), 'h20);
      wait_pops(2, "t5_delivery");
      out_ready = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("t6_full_valid", int'(out_valid), 1);
      chk("t6_full_stall", int'(imem_req), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_valid", int'(out_valid), 0);
      chk("t6_rst_req", int'(imem_req), 0);
      chk("t6_rst_pc", int'(out_pc), 0);
      chk("t6_rst_instr", int'(out_instr), 0);
      restart(8'h00);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_restart_req", int'(imem_req), 1);
      chk("t6_restart_addr", int'(imem_addr), 0);
      wait_pops(3, "t6_delivery");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
